// File: rtl/spcpu_mem_bus_ctrl.sv
// spcpu data-port to 16-bit synchronous RAM bridge: byte-addressed 8/16-bit requests become word accesses with byte enables.
// Latency: data_ready in cycle 3+WAIT_STATES (single beat) or 5+WAIT_STATES (misaligned split).
// Backpressure: none; req_rdwr is only sampled in IDLE. Optional stats counters under SPCPU_MEM_BUS_CTRL_STATS_EN.
module spcpu_mem_bus_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_rdwr,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  data_acc_sz,
    input  logic                  data_we,
    input  logic [15:0]           write_data,
    output logic [15:0]           read_data,
    output logic                  data_ready,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [1:0]            ram_be,
    output logic [ADDR_WIDTH-2:0] ram_addr,
    output logic [15:0]           ram_wdata,
    input  logic [15:0]           ram_rdata,
    output logic [15:0]           debug_acc_count,
    output logic [15:0]           debug_split_count
);

    // Encoding of data_acc_sz as used by the CPU package.
    localparam logic ACC_SZ_8  = 1'b0;
    localparam logic ACC_SZ_16 = 1'b1;

    localparam int RAW = ADDR_WIDTH - 1;
    localparam logic [RAW-1:0] WORD_ONE  = 1;
    localparam logic [3:0]     WAIT_LAST = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC0,
        ST_CAP0,
        ST_ACC1,
        ST_CAP1,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_sz;
    logic                  req_we;
    logic [15:0]           req_wdata;
    logic [3:0]            wait_cnt;
    logic                  misaligned;

    logic                  nxt_en;
    logic                  nxt_we;
    logic [1:0]            nxt_be;
    logic [RAW-1:0]        nxt_addr;
    logic [15:0]           nxt_wdata;

    assign misaligned = (req_sz == ACC_SZ_16) && req_addr[0];

    // State register plus request latch; the latch only opens in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            req_addr  <= '0;
            req_sz    <= ACC_SZ_8;
            req_we    <= 1'b0;
            req_wdata <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && req_rdwr) begin
                req_addr  <= addr_in;
                req_sz    <= data_acc_sz;
                req_we    <= data_we;
                req_wdata <= write_data;
            end
        end
    end

    // Wait-state counter: runs only while in WAIT, restarts from zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next-state decode; WAIT is skipped entirely when WAIT_STATES is zero.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (req_rdwr) next_state = ST_ACC0;
            ST_ACC0: next_state = ST_CAP0;
            ST_CAP0: begin
                if (misaligned)            next_state = ST_ACC1;
                else if (WAIT_STATES == 0) next_state = ST_DONE;
                else                       next_state = ST_WAIT;
            end
            ST_ACC1: next_state = ST_CAP1;
            ST_CAP1: next_state = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (wait_cnt == WAIT_LAST) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // RAM command for the upcoming state. ACC0 is only entered from IDLE, so
    // its fields come straight from the request inputs being latched this edge.
    always_comb begin
        nxt_en    = 1'b0;
        nxt_we    = 1'b0;
        nxt_be    = 2'b00;
        nxt_addr  = '0;
        nxt_wdata = '0;
        if (next_state == ST_ACC0) begin
            nxt_en   = 1'b1;
            nxt_we   = data_we;
            nxt_addr = addr_in[ADDR_WIDTH-1:1];
            if (data_acc_sz == ACC_SZ_8) begin
                nxt_be    = addr_in[0] ? 2'b10 : 2'b01;
                nxt_wdata = {write_data[7:0], write_data[7:0]};
            end else if (addr_in[0]) begin
                nxt_be    = 2'b10;
                nxt_wdata = {write_data[7:0], 8'h00};
            end else begin
                nxt_be    = 2'b11;
                nxt_wdata = write_data;
            end
        end else if (next_state == ST_ACC1) begin
            // Second half of a split: next word up, wrapping at the top of RAM.
            nxt_en    = 1'b1;
            nxt_we    = req_we;
            nxt_addr  = req_addr[ADDR_WIDTH-1:1] + WORD_ONE;
            nxt_be    = 2'b01;
            nxt_wdata = {8'h00, req_wdata[15:8]};
        end
    end

    // Registered RAM port and completion pulse; async reset kills a write at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_be     <= 2'b00;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            data_ready <= 1'b0;
        end else begin
            ram_en     <= nxt_en;
            ram_we     <= nxt_we;
            ram_be     <= nxt_be;
            ram_addr   <= nxt_addr;
            ram_wdata  <= nxt_wdata;
            data_ready <= (next_state == ST_DONE);
        end
    end

    // Read-data assembly from RAM lanes; writes never disturb read_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data <= '0;
        end else if (!req_we) begin
            if (state == ST_CAP0) begin
                if (req_sz == ACC_SZ_8) begin
                    read_data <= {8'h00, (req_addr[0] ? ram_rdata[15:8] : ram_rdata[7:0])};
                end else if (misaligned) begin
                    read_data[7:0] <= ram_rdata[15:8];
                end else begin
                    read_data <= ram_rdata;
                end
            end else if (state == ST_CAP1) begin
                read_data[15:8] <= ram_rdata[7:0];
            end
        end
    end

`ifdef SPCPU_MEM_BUS_CTRL_STATS_EN
    logic [15:0] acc_count;
    logic [15:0] split_count;

    // Completion counters, one step per request as it passes through DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_count   <= '0;
            split_count <= '0;
        end else if (state == ST_DONE) begin
            acc_count <= acc_count + 16'd1;
            if (misaligned) split_count <= split_count + 16'd1;
        end
    end

    assign debug_acc_count   = acc_count;
    assign debug_split_count = split_count;
`else
    assign debug_acc_count   = 16'h0000;
    assign debug_split_count = 16'h0000;
`endif

endmodule
